dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache.
- Sits between the core's load/store path and slow data memory.
- Responds to memread/memwrite word requests from the core and stalls it on a miss.
- Acts as the initiator of 128-bit block reads and writes toward memory.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_line_array.sv | 69 ++++++
 rtl/dcache_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the controller state encoding, the default geometry and the widths
// of the address fields (word offset, index, tag) derived from it.
package dcache_pkg;

    localparam int NUM_LINES_DEF = 8;
    localparam int WORD_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 30;

    // Word address layout: [1:0] word offset, [IDX_W+1:2] index, rest tag.
    localparam int OFF_W = 2;
    localparam int IDX_W = $clog2(NUM_LINES_DEF);
    localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W;
    localparam int BLK_W = 4 * WORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Storage for the cache lines: valid, dirty, tag and data per line.
// Ports:
//   clk, rst             clock and asynchronous active-high reset (clears
//                        valid and dirty only; tags and data keep contents)
//   idx                  line selected for both the read and the write port
//   rd_valid/rd_dirty/
//   rd_tag/rd_line       combinational read of the selected line
//   fill_we/fill_tag/
//   fill_data            full-line write: tag+data loaded, valid=1, dirty=0
//   word_we/word_off/
//   word_data            single-word write into the line, sets dirty
//   clean_we             clears dirty after the victim has been written back
module dcache_line_array #(
    parameter int NUM_LINES = 8,
    parameter int WORD_W    = 32,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    idx,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [4*WORD_W-1:0] rd_line,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [4*WORD_W-1:0] fill_data,
    input  logic                word_we,
    input  logic [1:0]          word_off,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                clean_we
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [4*WORD_W-1:0]  data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end else if (clean_we) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    // Tag and data arrays are deliberately not reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (word_we) begin
            data_q[idx][WORD_W*int'(word_off) +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk, proc_reset          clock, asynchronous active-high reset
//   proc_read/proc_write     core load/store request (both high = store)
//   proc_addr/proc_wdata     word address and store data
//   proc_rdata               load data, valid in the same cycle as a read hit
//   proc_stall               core must hold its request while high
//   mem_read/mem_write       block read/write request toward memory
//   mem_addr                 block address {tag,index}
//   mem_wdata/mem_rdata      victim block out / fill block in, word 0 at LSBs
//   mem_ready                one-cycle completion pulse from memory
//   dbg_state                current controller state
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [4*WORD_W-1:0] mem_wdata,
    input  logic [4*WORD_W-1:0] mem_rdata,
    input  logic                mem_ready,
    output state_t              dbg_state
);

    localparam int L_IDX_W = $clog2(NUM_LINES);
    localparam int L_TAG_W = ADDR_W - OFF_W - L_IDX_W;

    state_t state;

    logic [OFF_W-1:0]    off;
    logic [L_IDX_W-1:0]  idx;
    logic [L_TAG_W-1:0]  tag;
    logic                request;
    logic                hit;
    logic                line_valid;
    logic                line_dirty;
    logic [L_TAG_W-1:0]  line_tag;
    logic [4*WORD_W-1:0] line_data;
    logic                fill_we;
    logic                word_we;
    logic                clean_we;

    assign off = proc_addr[OFF_W-1:0];
    assign idx = proc_addr[OFF_W +: L_IDX_W];
    assign tag = proc_addr[ADDR_W-1 -: L_TAG_W];

    assign request = proc_read | proc_write;
    assign hit     = line_valid & (line_tag == tag);

    // Hits are only served from IDLE; any other state stalls a pending request.
    assign proc_stall = request & ~((state == IDLE) & hit);

    // A simultaneous read+write is handled as a write, so no load data then.
    assign proc_rdata = ((state == IDLE) && hit && proc_read && !proc_write)
                      ? line_data[WORD_W*int'(off) +: WORD_W] : '0;

    assign word_we  = (state == IDLE) & hit & proc_write;
    assign fill_we  = (state == ALLOCATE) & mem_ready;
    assign clean_we = (state == WRITEBACK) & mem_ready;

    assign dbg_state = state;

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .WORD_W    (WORD_W),
        .IDX_W     (L_IDX_W),
        .TAG_W     (L_TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (proc_reset),
        .idx       (idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_line   (line_data),
        .fill_we   (fill_we),
        .fill_tag  (tag),
        .fill_data (mem_rdata),
        .word_we   (word_we),
        .word_off  (off),
        .word_data (proc_wdata),
        .clean_we  (clean_we)
    );

    // Memory handshake: the cache raises exactly one of mem_read/mem_write
    // together with mem_addr (and mem_wdata for writes) and holds them all
    // constant until it samples mem_ready=1 on a rising edge; that edge
    // completes the transfer and the request drops in the following cycle.
    // mem_ready is ignored while no request is outstanding.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        if (line_valid && line_dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {line_tag, idx};
                            mem_wdata <= line_data;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                            mem_addr <= {tag, idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_wdata <= '0;
                        mem_read  <= 1'b1;
                        mem_addr  <= {tag, idx};
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule
